// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one DDR2 controller port among three burst requesters.
// Each grant runs a full burst: write data push, command issue, read drain, done pulse.
module mem_port_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int BL_W   = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     calib_done,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*BL_W-1:0]    req_bl,
    input  logic [N_REQ*DATA_W-1:0]  wr_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         wr_ack,
    output logic [DATA_W-1:0]        rd_data,
    output logic [N_REQ-1:0]         rd_valid,
    output logic [N_REQ-1:0]         done,
    output logic                     err,
    output logic                     p0_cmd_en,
    output logic [2:0]               p0_cmd_instr,
    output logic [ADDR_W-1:0]        p0_cmd_byte_addr,
    output logic [BL_W-1:0]          p0_cmd_bl,
    input  logic                     p0_cmd_full,
    output logic                     p0_wr_en,
    output logic [DATA_W-1:0]        p0_wr_data,
    output logic [3:0]               p0_wr_mask,
    input  logic                     p0_wr_full,
    input  logic                     p0_wr_error,
    output logic                     p0_rd_en,
    input  logic [DATA_W-1:0]        p0_rd_data,
    input  logic                     p0_rd_empty,
    input  logic                     p0_rd_error
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = BL_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_WDATA, S_CMD, S_RDATA, S_DONE} state_t;

    state_t              state_reg;
    logic [N_REQ-1:0]    gnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    last_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [BL_W-1:0]     bl_reg;
    logic [2:0]          instr_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [DATA_W-1:0]   rd_data_reg;
    logic [N_REQ-1:0]    rd_valid_reg;
    logic                err_reg;

    logic [ADDR_W-1:0]   addr_arr  [N_REQ];
    logic [BL_W-1:0]     bl_arr    [N_REQ];
    logic [DATA_W-1:0]   wdata_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign bl_arr[gi]    = req_bl[gi*BL_W +: BL_W];
            assign wdata_arr[gi] = wr_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan from farthest to nearest so the requester right after last wins.
    logic                win_valid;
    logic [IDX_W-1:0]    win_idx;
    logic [N_REQ-1:0]    win_onehot;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(last_reg) + k) % N_REQ]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'((int'(last_reg) + k) % N_REQ);
            end
        end
        win_onehot = N_REQ'(1) << win_idx;
    end

    logic wr_fire, cmd_fire, rd_fire, last_word;

    assign wr_fire   = (state_reg == S_WDATA) && !p0_wr_full;
    assign cmd_fire  = (state_reg == S_CMD)   && !p0_cmd_full;
    assign rd_fire   = (state_reg == S_RDATA) && !p0_rd_empty;
    assign last_word = (cnt_reg == CNT_W'(bl_reg));

    assign p0_wr_en         = wr_fire;
    assign p0_wr_data       = wr_fire ? wdata_arr[idx_reg] : '0;
    assign p0_wr_mask       = 4'b0000;
    assign p0_cmd_en        = cmd_fire;
    assign p0_cmd_instr     = instr_reg;
    assign p0_cmd_byte_addr = addr_reg;
    assign p0_cmd_bl        = bl_reg;
    assign p0_rd_en         = rd_fire;
    assign gnt              = gnt_reg;
    assign wr_ack           = wr_fire ? gnt_reg : '0;
    assign rd_data          = rd_data_reg;
    assign rd_valid         = rd_valid_reg;
    assign done             = (state_reg == S_DONE) ? gnt_reg : '0;
    assign err              = err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            gnt_reg      <= '0;
            idx_reg      <= '0;
            last_reg     <= IDX_W'(N_REQ - 1);
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            bl_reg       <= '0;
            instr_reg    <= 3'b000;
            cnt_reg      <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            rd_valid_reg <= rd_fire ? gnt_reg : '0;
            if (rd_fire)
                rd_data_reg <= p0_rd_data;
            if (p0_wr_error || p0_rd_error)
                err_reg <= 1'b1;

            case (state_reg)
                S_IDLE: begin
                    if (calib_done && win_valid) begin
                        idx_reg   <= win_idx;
                        gnt_reg   <= win_onehot;
                        we_reg    <= req_we[win_idx];
                        addr_reg  <= addr_arr[win_idx];
                        bl_reg    <= bl_arr[win_idx];
                        instr_reg <= req_we[win_idx] ? 3'b000 : 3'b001;
                        cnt_reg   <= '0;
                        state_reg <= req_we[win_idx] ? S_WDATA : S_CMD;
                    end
                end
                S_WDATA: begin
                    if (wr_fire) begin
                        if (last_word) begin
                            cnt_reg   <= '0;
                            state_reg <= S_CMD;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                S_CMD: begin
                    if (cmd_fire)
                        state_reg <= we_reg ? S_DONE : S_RDATA;
                end
                S_RDATA: begin
                    if (rd_fire) begin
                        if (last_word) begin
                            cnt_reg   <= '0;
                            state_reg <= S_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    gnt_reg   <= '0;
                    last_reg  <= idx_reg;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: write, read, round-robin, stalls, reset and error.
module tb_mem_port_arbiter;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int BL_W   = 6;

    logic                    clk = 1'b0;
    logic                    rst_n, calib_done;
    logic [N_REQ-1:0]        req, req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*BL_W-1:0]   req_bl;
    logic [N_REQ*DATA_W-1:0] wr_data;
    logic [N_REQ-1:0]        gnt, wr_ack, rd_valid, done;
    logic [DATA_W-1:0]       rd_data;
    logic                    err;
    logic                    p0_cmd_en;
    logic [2:0]              p0_cmd_instr;
    logic [ADDR_W-1:0]       p0_cmd_byte_addr;
    logic [BL_W-1:0]         p0_cmd_bl;
    logic                    p0_cmd_full;
    logic                    p0_wr_en;
    logic [DATA_W-1:0]       p0_wr_data;
    logic [3:0]              p0_wr_mask;
    logic                    p0_wr_full, p0_wr_error;
    logic                    p0_rd_en;
    logic [DATA_W-1:0]       p0_rd_data;
    logic                    p0_rd_empty, p0_rd_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Controller read FIFO model: returns 0,1,2,... one word per pop.
    logic [DATA_W-1:0] rd_ptr;
    logic              rd_ptr_clr;
    always @(posedge clk) begin
        if (rd_ptr_clr)
            rd_ptr <= '0;
        else if (p0_rd_en)
            rd_ptr <= rd_ptr + 1;
    end
    assign p0_rd_data = rd_ptr;

    mem_port_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BL_W(BL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_bl(req_bl),
        .wr_data(wr_data), .gnt(gnt), .wr_ack(wr_ack), .rd_data(rd_data),
        .rd_valid(rd_valid), .done(done), .err(err),
        .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr),
        .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_bl(p0_cmd_bl),
        .p0_cmd_full(p0_cmd_full), .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data),
        .p0_wr_mask(p0_wr_mask), .p0_wr_full(p0_wr_full), .p0_wr_error(p0_wr_error),
        .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data), .p0_rd_empty(p0_rd_empty),
        .p0_rd_error(p0_rd_error)
    );

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; calib_done = 1'b0; req = '0; req_we = '0;
        req_addr = '0; req_bl = '0; wr_data = '0;
        p0_cmd_full = 1'b0; p0_wr_full = 1'b0; p0_wr_error = 1'b0;
        p0_rd_empty = 1'b1; p0_rd_error = 1'b0; rd_ptr_clr = 1'b1;
        step; step;
        n_checks++;
        if ({gnt, wr_ack, rd_valid, done} !== 12'b0) begin
            n_fail++; $display("FAIL reset_hs: got %b expected 0", {gnt, wr_ack, rd_valid, done});
        end
        n_checks++;
        if ({p0_cmd_en, p0_wr_en, p0_rd_en, err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_en: got %b expected 0", {p0_cmd_en, p0_wr_en, p0_rd_en, err});
        end
        n_checks++;
        if ({p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl} !== 39'b0) begin
            n_fail++; $display("FAIL reset_cmd: got %h expected 0", {p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl});
        end
        n_checks++;
        if ({rd_data, p0_wr_mask} !== 36'b0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {rd_data, p0_wr_mask});
        end
        rst_n = 1'b1; rd_ptr_clr = 1'b0; req = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step;
            n_checks++;
            if (gnt !== 3'b000) begin
                n_fail++; $display("FAIL no_calib_gnt: got %b expected 000", gnt);
            end
        end
        req = '0; calib_done = 1'b1;
        step;
        $display("test_reset done");
    endtask

    task automatic test_write;
        int acks = 0, first_ack = -1, last_ack = -1, cmd_cnt = 0, cmd_cyc = -1, done_cyc = -1;
        req_we = 3'b001; req_addr[0 +: ADDR_W] = 30'h100; req_bl[0 +: BL_W] = 6'd3;
        req = 3'b001;
        for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
            step;
            if (gnt[0]) req = 3'b000;
            wr_data[0 +: DATA_W] = 32'hA000_0000 + acks;
            #1;
            if (wr_ack[0]) begin
                n_checks++;
                if (p0_wr_data !== 32'hA000_0000 + acks || p0_wr_en !== 1'b1) begin
                    n_fail++; $display("FAIL wr_push: got en=%b data=%h expected en=1 data=%h",
                                       p0_wr_en, p0_wr_data, 32'hA000_0000 + acks);
                end
                if (first_ack < 0) first_ack = cyc;
                last_ack = cyc;
                acks++;
            end
            if (p0_cmd_en) begin
                cmd_cnt++; cmd_cyc = cyc;
                n_checks++;
                if ({p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl} !== {3'b000, 30'h100, 6'd3}) begin
                    n_fail++; $display("FAIL wr_cmd: got instr=%b addr=%h bl=%0d expected 000/100/3",
                                       p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl);
                end
            end
            if (done[0]) done_cyc = cyc;
        end
        n_checks++;
        if (acks !== 4 || last_ack - first_ack !== 3) begin
            n_fail++; $display("FAIL wr_ack_count: got %0d acks over span %0d expected 4 over 3", acks, last_ack - first_ack);
        end
        n_checks++;
        if (cmd_cnt !== 1 || cmd_cyc !== last_ack + 1) begin
            n_fail++; $display("FAIL wr_cmd_timing: got %0d cmds at %0d expected 1 at %0d", cmd_cnt, cmd_cyc, last_ack + 1);
        end
        n_checks++;
        if (done_cyc !== cmd_cyc + 1) begin
            n_fail++; $display("FAIL wr_done: got cycle %0d expected %0d", done_cyc, cmd_cyc + 1);
        end
        step;
        n_checks++;
        if ({gnt, done} !== 6'b0) begin
            n_fail++; $display("FAIL wr_release: got gnt=%b done=%b expected 0", gnt, done);
        end
        $display("test_write done: %0d acks, cmd at %0d, done at %0d", acks, cmd_cyc, done_cyc);
    endtask

    task automatic test_read_toggle;
        int nv = 0, done_cyc = -1;
        rd_ptr_clr = 1'b1; step; rd_ptr_clr = 1'b0;
        req_we = 3'b000; req_addr[ADDR_W +: ADDR_W] = 30'h200; req_bl[BL_W +: BL_W] = 6'd7;
        req = 3'b010;
        for (int cyc = 0; cyc < 120 && done_cyc < 0; cyc++) begin
            step;
            if (gnt[1]) req = 3'b000;
            p0_rd_empty = ~p0_rd_empty;
            #1;
            if (rd_valid !== 3'b000) begin
                n_checks++;
                if (rd_valid !== 3'b010 || rd_data !== DATA_W'(nv)) begin
                    n_fail++; $display("FAIL rd_word: got valid=%b data=%0d expected valid=010 data=%0d", rd_valid, rd_data, nv);
                end
                nv++;
            end
            if (done[1]) begin
                done_cyc = cyc;
                n_checks++;
                if (rd_valid[1] !== 1'b1) begin
                    n_fail++; $display("FAIL rd_done_align: got rd_valid[1]=%b expected 1", rd_valid[1]);
                end
            end
        end
        n_checks++;
        if (done_cyc < 0 || nv !== 8) begin
            n_fail++; $display("FAIL rd_count: got %0d words done_cyc=%0d expected 8 words with done", nv, done_cyc);
        end
        p0_rd_empty = 1'b1;
        $display("test_read_toggle done: %0d words, done at %0d", nv, done_cyc);
    endtask

    task automatic test_round_robin;
        int order[$];
        int bad_hot = 0, bad_gap = 0, idx;
        logic [N_REQ-1:0] prev = '0;
        rst_n = 1'b0; step; rst_n = 1'b1;
        req_we = 3'b000; req_bl = '0; p0_rd_empty = 1'b0; req = 3'b111;
        for (int cyc = 0; cyc < 100 && order.size() < 6; cyc++) begin
            step;
            if ($countones(gnt) > 1) bad_hot++;
            if (gnt != 0 && prev != 0 && gnt != prev) bad_gap++;
            if (gnt != 0 && prev == 0) begin
                idx = -1;
                for (int b = 0; b < N_REQ; b++) if (gnt[b]) idx = b;
                order.push_back(idx);
            end
            prev = gnt;
        end
        req = 3'b000;
        n_checks++;
        if (bad_hot !== 0 || bad_gap !== 0) begin
            n_fail++; $display("FAIL rr_onehot: got %0d non-onehot, %0d gapless cycles expected 0", bad_hot, bad_gap);
        end
        n_checks++;
        if (order.size() !== 6) begin
            n_fail++; $display("FAIL rr_count: got %0d grants expected 6", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            n_checks++;
            if (order[i] !== i % 3) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % 3);
            end
        end
        repeat (6) step;
        n_checks++;
        if (gnt !== 3'b000) begin
            n_fail++; $display("FAIL rr_idle: got %b expected 000", gnt);
        end
        $display("test_round_robin done: %0d grants", order.size());
    endtask

    task automatic test_cmd_full;
        int cmd_seen = 0;
        p0_cmd_full = 1'b1; p0_rd_empty = 1'b0;
        req_we = 3'b000; req_addr[0 +: ADDR_W] = 30'h3C0; req_bl[0 +: BL_W] = 6'd0;
        req = 3'b001;
        for (int i = 0; i < 10 && gnt[0] !== 1'b1; i++) step;
        n_checks++;
        if (gnt !== 3'b001) begin
            n_fail++; $display("FAIL cf_grant: got %b expected 001", gnt);
        end
        req = 3'b000;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step;
            if (p0_cmd_en) cmd_seen++;
        end
        n_checks++;
        if (cmd_seen !== 0) begin
            n_fail++; $display("FAIL cf_hold: got %0d cmd_en expected 0", cmd_seen);
        end
        n_checks++;
        if ({p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl} !== {3'b001, 30'h3C0, 6'd0}) begin
            n_fail++; $display("FAIL cf_fields: got instr=%b addr=%h bl=%0d expected 001/3c0/0", p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl);
        end
        step;
        p0_cmd_full = 1'b0;
        #1;
        n_checks++;
        if (p0_cmd_en !== 1'b1) begin
            n_fail++; $display("FAIL cf_release: got cmd_en=%b expected 1", p0_cmd_en);
        end
        step;
        n_checks++;
        if (p0_cmd_en !== 1'b0) begin
            n_fail++; $display("FAIL cf_single: got cmd_en=%b expected 0", p0_cmd_en);
        end
        for (int i = 0; i < 10 && done[0] !== 1'b1; i++) step;
        n_checks++;
        if (done !== 3'b001) begin
            n_fail++; $display("FAIL cf_done: got %b expected 001", done);
        end
        step;
        $display("test_cmd_full done");
    endtask

    task automatic test_reset_midburst;
        int acks = 0, done1 = 0, done0 = 0;
        p0_cmd_full = 1'b0; p0_wr_full = 1'b0;
        req_we = 3'b010; req_addr[ADDR_W +: ADDR_W] = 30'h40; req_bl[BL_W +: BL_W] = 6'd63;
        wr_data[DATA_W +: DATA_W] = 32'h5555_5555;
        req = 3'b010;
        for (int cyc = 0; cyc < 60 && acks < 20; cyc++) begin
            step;
            if (gnt[1]) req = 3'b000;
            if (wr_ack[1]) acks++;
            if (done != 0) done1++;
        end
        n_checks++;
        if (acks !== 20) begin
            n_fail++; $display("FAIL mb_acks: got %0d expected 20", acks);
        end
        rst_n = 1'b0;
        step;
        rst_n = 1'b1; req_we = 3'b000; req_bl = '0; req = 3'b011; p0_rd_empty = 1'b0;
        #1;
        n_checks++;
        if ({gnt, wr_ack, rd_valid, done, p0_cmd_en, p0_wr_en, p0_rd_en} !== 15'b0) begin
            n_fail++; $display("FAIL mb_outputs: got %b expected 0", {gnt, wr_ack, rd_valid, done, p0_cmd_en, p0_wr_en, p0_rd_en});
        end
        n_checks++;
        if ({p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl, rd_data} !== 71'b0) begin
            n_fail++; $display("FAIL mb_fields: got %h expected 0", {p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl, rd_data});
        end
        step;
        n_checks++;
        if (gnt !== 3'b001) begin
            n_fail++; $display("FAIL mb_regrant: got %b expected 001", gnt);
        end
        req = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (done[1]) done1++;
            if (done[0]) done0++;
            step;
        end
        n_checks++;
        if (done1 !== 0 || done0 !== 1) begin
            n_fail++; $display("FAIL mb_done: got done1=%0d done0=%0d expected 0 and 1", done1, done0);
        end
        $display("test_reset_midburst done: %0d acks before reset", acks);
    endtask

    task automatic test_err;
        int low_seen = 0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL err_init: got %b expected 0", err);
        end
        p0_rd_error = 1'b1;
        #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL err_early: got %b expected 0", err);
        end
        step;
        p0_rd_error = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_rise: got %b expected 1", err);
        end
        for (int i = 0; i < 5; i++) begin
            step;
            if (err !== 1'b1) low_seen++;
        end
        n_checks++;
        if (low_seen !== 0) begin
            n_fail++; $display("FAIL err_sticky: got %0d low cycles expected 0", low_seen);
        end
        rst_n = 1'b0; step; rst_n = 1'b1; #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: got %b expected 0", err);
        end
        $display("test_err done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_write;
        test_read_toggle;
        test_round_robin;
        test_cmd_full;
        test_reset_midburst;
        test_err;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
